load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  MEM-stage front end for the word-only synchronous data memory (1-cycle read, full-word write,
//  no byte enables). Turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses.
//  Sub-word stores use a read-modify-write; loads get lane select and sign/zero extension.
//  Misaligned or illegal accesses are flagged, not executed. Pipeline is held via stall.
// PARAMETERS
//  address_width  12  byte-address width; word index = addr[address_width-1:2]
//  data_width     32  word width; only 32 is supported
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous, active-low reset
//  req_valid       in   1   MEM stage presents an access; held stable while stall=1
//  req_write       in   1   1=store, 0=load
//  req_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
//  req_addr        in   address_width  byte address from ALU
//  req_wdata       in   32  store data (rs2)
//  stall           out  1   hold PC/IF/ID/EX/MEM registers this cycle
//  rsp_valid       out  1   rsp_rdata valid for the MEM/WB register this cycle
//  rsp_rdata       out  32  extended load result
//  fault           out  1   one-cycle pulse: misaligned/illegal access suppressed
//  mem_write       out  1   to data memory write enable
//  mem_address     out  address_width  to data memory address
//  mem_write_data  out  32  to data memory write data
//  mem_read_data   in   32  from data memory; valid the cycle after a read address
// BEHAVIOUR
//  States: IDLE, LD_DATA, ST_MERGE. Requests are accepted only in IDLE; the request
//   (addr, funct3, wdata) is latched at accept, and later states use only the latched copy.
//  Reset (async): state=IDLE, latches=0. stall, rsp_valid, fault, mem_write = 0; rsp_rdata = 0.
//   mem_write is forced 0 while rst_n=0.
//  IDLE, no request: mem_address=req_addr, mem_write=0, stall=0.
//  Alignment rules: H/HU need addr[0]=0; W needs addr[1:0]=0. Illegal funct3 values are
//   011/110/111 for loads and any value other than 000/001/010 for stores.
//  Misaligned or illegal request in IDLE: fault=1 for that cycle, mem_write=0, stall=0,
//   rsp_valid=0, stay IDLE.
//  SW (aligned): single cycle in IDLE; mem_write=1, mem_write_data=req_wdata, stall=0.
//  Load: IDLE drives the read (mem_write=0) with stall=1 -> LD_DATA.
//   LD_DATA: rsp_valid=1, stall=0, rsp_rdata=extend(mem_read_data) -> IDLE. Latency: 2 cycles.
//   Lane = addr[1:0]. Byte = word[8*lane+:8]; half = word[16*addr[1]+:16].
//   B/H sign-extend; BU/HU zero-extend.
//  SB/SH: IDLE issues the read, stall=1 -> ST_MERGE.
//   ST_MERGE: mem_write=1, mem_address=latched addr, mem_write_data=mem_read_data with the
//   target lane(s) replaced by wdata[7:0] / wdata[15:0]; stall=0 -> IDLE. 2 cycles, one write.
//  Back-to-back: a new request presented in the cycle after LD_DATA/ST_MERGE is accepted normally.
//  req_valid dropping during LD_DATA/ST_MERGE is ignored; the latched op completes.
//  Reset mid-operation: return to IDLE; a pending ST_MERGE write is abandoned, so memory
//   keeps its old word.
//  mem_address is always word-meaningful; bits [1:0] are passed through and ignored by memory.
// STRUCTURE
//  ls_pkg: funct3 encodings, state encoding, width constants.
//  Sub-module load_extend (combinational): word, addr[1:0], funct3 -> 32-bit extended result.
//  Store merge and FSM stay in this module.
// TESTING
//  1 mem[0x10]=0x8899AABB; LB @0x13 -> rsp_rdata=0xFFFFFF88, rsp_valid 2nd cycle, stall 1 cycle.
//  2 Same word; LBU @0x12 -> 0x00000099; LHU @0x10 -> 0x0000AABB; LH @0x12 -> 0xFFFF8899.
//  3 SB 0x5A @0x21 over 0x11223344 -> mem=0x11225A44; SH 0xBEEF @0x22 -> 0xBEEF5A44.
//    Exactly one mem_write pulse each.
//  4 SW @0x32 and LH @0x31 -> fault pulse, no mem_write, memory unchanged, stall=0.
//  5 Reset asserted in ST_MERGE of SB -> no write, all outputs 0; next LW returns the old word.
//  6 Back-to-back SW, LW same addr, SB, LW -> each LW returns the latest stored value.

Source files
------------

// File: rtl/ls_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states and the
// access-legality helper used at request time.
package ls_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_DATA  = 2'd1,
    ST_ST_MERGE = 2'd2
  } ls_state_t;

  // True when the access is both a legal funct3 for its direction and naturally aligned.
  function automatic logic access_ok(input logic write, input logic [2:0] funct3,
                                     input logic [1:0] lane);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = ~write;
      F3_HU:   ok = ~write & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_extend
  import ls_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage front end: maps RV32I loads/stores onto a word-only synchronous memory,
// using read-modify-write for sub-word stores and stalling the pipeline while busy.
module load_store_unit
  import ls_pkg::*;
#(
  parameter int address_width = 12,
  parameter int data_width    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [address_width-1:0] req_addr,
  input  logic [data_width-1:0]    req_wdata,
  output logic                     stall,
  output logic                     rsp_valid,
  output logic [data_width-1:0]    rsp_rdata,
  output logic                     fault,
  output logic                     mem_write,
  output logic [address_width-1:0] mem_address,
  output logic [data_width-1:0]    mem_write_data,
  input  logic [data_width-1:0]    mem_read_data
);

  ls_state_t                  state_reg, state_next;
  logic [address_width-1:0]   addr_reg;
  logic [2:0]                 funct3_reg;
  logic [15:0]                wdata_reg;
  logic                       in_idle, req_ok, accept, reject;
  logic [data_width-1:0]      ext_result, merged;

  assign in_idle = (state_reg == ST_IDLE);
  assign req_ok  = access_ok(req_write, req_funct3, req_addr[1:0]);
  assign accept  = in_idle & req_valid & req_ok;
  assign reject  = in_idle & req_valid & ~req_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      funct3_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= req_addr;
        funct3_reg <= req_funct3;
        wdata_reg  <= req_wdata[15:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!req_write)              state_next = ST_LD_DATA;
          else if (req_funct3 != F3_W) state_next = ST_ST_MERGE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .word   (mem_read_data),
    .lane   (addr_reg[1:0]),
    .funct3 (funct3_reg),
    .result (ext_result)
  );

  // Only byte and half stores ever reach the merge state.
  always_comb begin
    merged = mem_read_data;
    if (funct3_reg == F3_B) merged[{addr_reg[1:0], 3'b000} +: 8] = wdata_reg[7:0];
    else                    merged[{addr_reg[1], 4'b0000} +: 16] = wdata_reg;
  end

  always_comb begin
    stall          = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    fault          = 1'b0;
    mem_write      = 1'b0;
    mem_address    = req_addr;
    mem_write_data = req_wdata;
    case (state_reg)
      ST_IDLE: begin
        fault = reject;
        if (accept) begin
          if (req_write && req_funct3 == F3_W) mem_write = 1'b1;
          else                                 stall = 1'b1;
        end
      end
      ST_LD_DATA: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = ext_result;
        mem_address = addr_reg;
      end
      ST_ST_MERGE: begin
        mem_write      = 1'b1;
        mem_address    = addr_reg;
        mem_write_data = merged;
      end
      default: ;
    endcase
    // Outputs are quiet while reset is held, so an in-flight merge write is dropped.
    if (!rst_n) begin
      stall     = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      fault     = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: drives directed and random accesses into load_store_unit
// backed by a word memory, and compares against an array-based reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall, rsp_valid, fault, mem_write;
  logic [31:0] rsp_rdata, mem_write_data, mem_read_data;
  logic [11:0] mem_address;
  logic        mem_clear;

  logic [31:0] phys_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  load_store_unit #(.address_width(12), .data_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) phys_mem[i] <= '0;
    end else if (mem_write) begin
      phys_mem[mem_address[11:2]] <= mem_write_data;
    end
    mem_read_data <= phys_mem[mem_address[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input bit w, input int f3, input int a);
    case (f3)
      0:       return 1'b1;
      1:       return (a % 2) == 0;
      2:       return (a % 4) == 0;
      4:       return !w;
      5:       return !w && (a % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int a);
    int unsigned word, b, h;
    word = ref_mem[a / 4];
    b = (word >> (8 * (a % 4))) & 32'hFF;
    h = (word >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      0:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4:       return b;
      5:       return h;
      default: return word;
    endcase
  endfunction

  task automatic ref_store(input int f3, input int a, input int unsigned d);
    int unsigned word, sh, mask;
    word = ref_mem[a / 4];
    if (f3 == 2) begin
      word = d;
    end else begin
      sh   = (f3 == 0) ? 8 * (a % 4) : 16 * ((a % 4) / 2);
      mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << sh;
      word = (word & ~mask) | ((d << sh) & mask);
    end
    ref_mem[a / 4] = word;
  endtask

  // One transaction: hold the request until the unit stops stalling, then score it.
  task automatic run(input bit w, input logic [2:0] f3, input logic [11:0] a,
                     input logic [31:0] d, input bit drop);
    int cyc, wr, exp_cyc;
    bit flt, got, ok;
    logic [31:0] rd;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    cyc = 0; wr = 0; flt = 0; got = 0; rd = '0;
    for (int i = 0; i < 6; i++) begin
      #1;
      cyc++;
      if (mem_write) wr++;
      if (fault) flt = 1'b1;
      if (rsp_valid) begin got = 1'b1; rd = rsp_rdata; end
      if (!stall) break;
      @(negedge clk);
      if (drop) req_valid = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b0;
    ok = ref_legal(w, int'(f3), int'(a));
    exp_cyc = (!ok || (w && f3 == 3'b010)) ? 1 : 2;
    check("cycles", cyc, exp_cyc);
    check("writes", wr, (ok && w) ? 1 : 0);
    check("fault", {31'b0, flt}, {31'b0, !ok});
    check("rsp_seen", {31'b0, got}, {31'b0, ok && !w});
    if (ok && !w) check("rdata", rd, ref_load(int'(f3), int'(a)));
    if (ok && w) ref_store(int'(f3), int'(a), d);
    check("mem_word", phys_mem[a[11:2]], ref_mem[int'(a) / 4]);
    last_rd = rd;
    $display("txn w=%0d f3=%0d addr=%h wdata=%h drop=%0d cycles=%0d writes=%0d fault=%0d rdata=%h",
             w, f3, a, d, drop, cyc, wr, flt, rd);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    rst_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    last_rd = '0;
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_clear = 1'b0;
    @(negedge clk);

    // Sub-word loads from one word
    run(1, 3'b010, 12'h010, 32'h8899AABB, 0);
    run(0, 3'b000, 12'h013, 32'h0, 0); check("t1_lb", last_rd, 32'hFFFFFF88);
    run(0, 3'b100, 12'h012, 32'h0, 0); check("t2_lbu", last_rd, 32'h00000099);
    run(0, 3'b101, 12'h010, 32'h0, 0); check("t2_lhu", last_rd, 32'h0000AABB);
    run(0, 3'b001, 12'h012, 32'h0, 0); check("t2_lh", last_rd, 32'hFFFF8899);

    // Read-modify-write stores
    run(1, 3'b010, 12'h020, 32'h11223344, 0);
    run(1, 3'b000, 12'h021, 32'h0000005A, 0); check("t3_sb", phys_mem[8], 32'h11225A44);
    run(1, 3'b001, 12'h022, 32'h0000BEEF, 0); check("t3_sh", phys_mem[8], 32'hBEEF5A44);

    // Misaligned and illegal accesses
    run(1, 3'b010, 12'h032, 32'hDEADBEEF, 0);
    run(0, 3'b001, 12'h031, 32'h0, 0);
    run(1, 3'b100, 12'h030, 32'h12345678, 0);
    run(0, 3'b011, 12'h030, 32'h0, 0);

    // Reset while a byte store is merging
    run(1, 3'b010, 12'h040, 32'hCAFEF00D, 0);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 12'h041;
    req_wdata = 32'h00000077;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_stall", {31'b0, stall}, 32'd0);
    check("mrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mrst_fault", {31'b0, fault}, 32'd0);
    check("mrst_mem_write", {31'b0, mem_write}, 32'd0);
    check("mrst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    check("mrst_mem", phys_mem[16], 32'hCAFEF00D);
    run(0, 3'b010, 12'h040, 32'h0, 0); check("t5_lw", last_rd, 32'hCAFEF00D);

    // Back-to-back store/load chains, with req_valid dropped mid-op
    run(1, 3'b010, 12'h050, 32'h0BADC0DE, 0);
    run(0, 3'b010, 12'h050, 32'h0, 0); check("t6_lw1", last_rd, 32'h0BADC0DE);
    run(1, 3'b000, 12'h052, 32'h000000E1, 1);
    run(0, 3'b010, 12'h050, 32'h0, 1); check("t6_lw2", last_rd, 32'h0BE1C0DE);

    // Random traffic over a small window so loads revisit stored words
    for (int n = 0; n < 150; n++) begin
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 12'($urandom_range(0, 127)),
          $urandom, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
